// File: rtl/avr_spi_mstr_sched_if.sv
// Bundle between the SPI burst scheduler, its NREQ requesters and the shared SPI master byte engine.
// master = scheduler side, slave = requesters plus byte engine.
interface avr_spi_mstr_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [4*NREQ-1:0] req_cfg;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              xfer_start;
  logic [7:0]        xfer_data;
  logic [3:0]        xfer_cfg;
  logic              xfer_done;
  logic [7:0]        xfer_rdata;
  logic [NREQ-1:0]   ss_b;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  req_valid, req_last, req_data, req_cfg, xfer_done, xfer_rdata,
    output req_ready, rsp_valid, rsp_data, xfer_start, xfer_data, xfer_cfg,
           ss_b, busy, timeout_err
  );

  modport slave (
    output req_valid, req_last, req_data, req_cfg, xfer_done, xfer_rdata,
    input  req_ready, rsp_valid, rsp_data, xfer_start, xfer_data, xfer_cfg,
           ss_b, busy, timeout_err
  );
endinterface

// File: rtl/avr_spi_mstr_sched.sv
// Per-burst round-robin scheduler sharing one SPI master byte engine among NREQ requesters.
// Optional WAIT/NEXT watchdog enabled by defining AVR_SPI_SCHED_TIMEOUT_EN.
module avr_spi_mstr_sched #(
  parameter int NREQ      = 2,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  avr_spi_mstr_sched_if.master bus
);

  localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > SETUP_CYC && TIMEOUT > GAP_CYC) ? TIMEOUT :
                           ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [NREQ-1:0] SEL0 = NREQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    NEXT,
    GAP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [OW-1:0]  owner;
  logic [OW-1:0]  rr_ptr;
  logic [OW-1:0]  grant_idx;
  logic           grant_found;
  logic           last;
  logic [CW-1:0]  cnt;
  logic           timeout_abort;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && bus.req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = OW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

`ifdef AVR_SPI_SCHED_TIMEOUT_EN
  assign timeout_abort = ((state == WAIT && !bus.xfer_done) ||
                          (state == NEXT && !bus.req_valid[owner])) &&
                         (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_found) state_nxt = SETUP;
      SETUP: if (cnt == CW'(SETUP_CYC - 1)) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (bus.xfer_done) begin
          state_nxt = last ? GAP : NEXT;
        end else if (timeout_abort) begin
          state_nxt = GAP;
        end
      end
      NEXT: begin
        if (bus.req_valid[owner]) begin
          state_nxt = START;
        end else if (timeout_abort) begin
          state_nxt = GAP;
        end
      end
      GAP:   if (cnt == CW'(GAP_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shared cycle counter, cleared on every state change and saturating otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (cnt != {CW{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner          <= '0;
      rr_ptr         <= '0;
      last           <= 1'b0;
      bus.ss_b       <= '1;
      bus.xfer_cfg   <= '0;
      bus.xfer_data  <= '0;
      bus.xfer_start <= 1'b0;
      bus.req_ready  <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_data   <= '0;
    end else begin
      bus.xfer_start <= 1'b0;
      bus.req_ready  <= '0;
      bus.rsp_valid  <= '0;

      if (state == IDLE && grant_found) begin
        owner        <= grant_idx;
        bus.xfer_cfg <= bus.req_cfg[4*grant_idx +: 4];
        bus.ss_b     <= ~(SEL0 << grant_idx);
      end

      // Byte is taken on the edge into START so xfer_data is already stable with xfer_start.
      if (state_nxt == START) begin
        bus.xfer_start <= 1'b1;
        bus.req_ready  <= SEL0 << owner;
        bus.xfer_data  <= bus.req_data[8*owner +: 8];
        last           <= bus.req_last[owner];
      end

      if (state == WAIT && bus.xfer_done) begin
        bus.rsp_data  <= bus.xfer_rdata;
        bus.rsp_valid <= SEL0 << owner;
      end

      if (state_nxt == GAP && state != GAP) begin
        bus.ss_b <= '1;
        rr_ptr   <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

`ifdef AVR_SPI_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.timeout_err <= 1'b0;
    end else if (timeout_abort) begin
      bus.timeout_err <= 1'b1;
    end
  end
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_avr_spi_mstr_sched.sv
// Directed bench for avr_spi_mstr_sched: scoreboard queues for transfers and responses plus
// per-step timing checks; the watchdog step runs only when AVR_SPI_SCHED_TIMEOUT_EN is defined.
module tb_avr_spi_mstr_sched;

  localparam int NREQ      = 2;
  localparam int SETUP_CYC = 2;
  localparam int GAP_CYC   = 4;
  localparam int TIMEOUT   = 16;

  typedef struct {
    logic [3:0] cfg;
    logic [7:0] data;
  } xfer_exp_t;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [7:0]      data;
  } rsp_exp_t;

  logic clk;
  logic rst;
  logic done_resp;
  logic done_manual;
  logic [7:0] rdata_resp;
  logic [7:0] rdata_manual;
  logic resp_en;
  int   resp_lat;
  int   checks;
  int   errors;

  xfer_exp_t  exp_xfer_q[$];
  rsp_exp_t   exp_rsp_q[$];
  logic [7:0] rdata_q[$];

  avr_spi_mstr_sched_if #(.NREQ(NREQ)) bus ();

  avr_spi_mstr_sched #(
    .NREQ      (NREQ),
    .SETUP_CYC (SETUP_CYC),
    .GAP_CYC   (GAP_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.xfer_done  = done_resp | done_manual;
  assign bus.xfer_rdata = done_manual ? rdata_manual : rdata_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic l,
                               input logic [7:0] d, input logic [3:0] c);
    bus.req_valid[r]       = v;
    bus.req_last[r]        = l;
    bus.req_data[8*r +: 8] = d;
    bus.req_cfg[4*r +: 4]  = c;
  endtask

  task automatic expect_byte(input int r, input logic [3:0] c, input logic [7:0] d,
                             input logic [7:0] rd, input bit with_rsp);
    xfer_exp_t xe;
    rsp_exp_t  re;
    xe.cfg  = c;
    xe.data = d;
    exp_xfer_q.push_back(xe);
    if (with_rsp) begin
      rdata_q.push_back(rd);
      re.mask = NREQ'(1) << r;
      re.data = rd;
      exp_rsp_q.push_back(re);
    end
  endtask

  task automatic wait_busy_low(input string tag);
    for (int c = 0; c < 100 && bus.busy; c++) tick();
    checkOutput(tag, bus.busy, 0);
  endtask

  task automatic wait_ready(input int r, input string tag);
    bit found;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.req_ready[r]) begin
        found = 1;
        break;
      end
    end
    checkOutput(tag, found, 1);
  endtask

  // Byte-engine model: answers each xfer_start after resp_lat cycles with the next queued rx byte.
  initial begin
    done_resp  = 1'b0;
    rdata_resp = 8'h00;
    forever begin
      @(negedge clk);
      if (resp_en && bus.xfer_start) begin
        repeat (resp_lat) @(posedge clk);
        #1;
        rdata_resp = (rdata_q.size() != 0) ? rdata_q.pop_front() : 8'h00;
        done_resp  = 1'b1;
        @(posedge clk);
        #1;
        done_resp  = 1'b0;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    xfer_exp_t xe;
    rsp_exp_t  re;
    checkOutput("ss_b_at_most_one_low", ($countones(~bus.ss_b) <= 1), 1);
    if (bus.xfer_start) begin
      checkOutput("xfer_expected", (exp_xfer_q.size() != 0), 1);
      if (exp_xfer_q.size() != 0) begin
        xe = exp_xfer_q.pop_front();
        checkOutput("xfer_data", bus.xfer_data, xe.data);
        checkOutput("xfer_cfg", bus.xfer_cfg, xe.cfg);
      end
    end
    if (bus.rsp_valid != '0) begin
      checkOutput("rsp_expected", (exp_rsp_q.size() != 0), 1);
      if (exp_rsp_q.size() != 0) begin
        re = exp_rsp_q.pop_front();
        checkOutput("rsp_valid", bus.rsp_valid, re.mask);
        checkOutput("rsp_data", bus.rsp_data, re.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit found;
    int n_rsp;
    int n_ready;
    int prev_start;
    int cyc;
    int high;
    int grants;

    checks        = 0;
    errors        = 0;
    resp_en       = 1'b1;
    resp_lat      = 2;
    done_manual   = 1'b0;
    rdata_manual  = 8'h00;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.req_cfg   = '0;
    rst           = 1'b1;

    // Reset values
    tick();
    tick();
    checkOutput("rst_ss_b", bus.ss_b, 2'b11);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_xfer_start", bus.xfer_start, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_timeout_err", bus.timeout_err, 0);
    checkOutput("rst_xfer_data", bus.xfer_data, 0);
    checkOutput("rst_xfer_cfg", bus.xfer_cfg, 0);
    checkOutput("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;
    tick();

    // Single byte on req0: setup latency, cfg/data, response, gap.
    $display("[TB] step 1: single byte on req0");
    resp_lat = 3;
    expect_byte(0, 4'b0100, 8'hA5, 8'h3C, 1);
    applyStimulus(0, 1, 1, 8'hA5, 4'b0100);
    tick();
    checkOutput("t1_ss_b_low", bus.ss_b, 2'b10);
    checkOutput("t1_busy", bus.busy, 1);
    checkOutput("t1_no_early_start", bus.xfer_start, 0);
    tick();
    checkOutput("t1_no_early_start2", bus.xfer_start, 0);
    tick();
    checkOutput("t1_start", bus.xfer_start, 1);
    checkOutput("t1_ready", bus.req_ready, 2'b01);
    checkOutput("t1_cfg", bus.xfer_cfg, 4'h4);
    checkOutput("t1_data", bus.xfer_data, 8'hA5);
    applyStimulus(0, 0, 0, 8'h00, 4'b0100);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.rsp_valid != '0) begin
        found = 1;
        break;
      end
    end
    checkOutput("t1_rsp_seen", found, 1);
    checkOutput("t1_rsp_valid", bus.rsp_valid, 2'b01);
    checkOutput("t1_rsp_data", bus.rsp_data, 8'h3C);
    for (int g = 0; g < GAP_CYC; g++) begin
      checkOutput("t1_gap_ss_b", bus.ss_b, 2'b11);
      checkOutput("t1_gap_busy", bus.busy, 1);
      tick();
    end
    checkOutput("t1_idle_after_gap", bus.busy, 0);

    // Both requesters continuously: rr_ptr is 1 now so req1 wins first, then strict alternation.
    $display("[TB] step 2: contention, alternating grants");
    resp_lat = 1;
    expect_byte(1, 4'hB, 8'h61, 8'hD1, 1);
    expect_byte(0, 4'h4, 8'h50, 8'hD2, 1);
    expect_byte(1, 4'hB, 8'h61, 8'hD3, 1);
    expect_byte(0, 4'h4, 8'h50, 8'hD4, 1);
    applyStimulus(0, 1, 1, 8'h50, 4'h4);
    applyStimulus(1, 1, 1, 8'h61, 4'hB);
    n_rsp  = 0;
    grants = 0;
    high   = 1;
    for (int c = 0; c < 300 && n_rsp < 4; c++) begin
      tick();
      if (bus.ss_b == 2'b11) begin
        high++;
      end else begin
        if (high != 0) begin
          checkOutput("t2_grant_order", bus.ss_b, (grants % 2 == 0) ? 2'b01 : 2'b10);
          if (grants > 0) checkOutput("t2_gap_len", (high >= GAP_CYC), 1);
          grants++;
        end
        high = 0;
      end
      if (bus.rsp_valid != '0) begin
        n_rsp++;
        if (n_rsp == 4) begin
          applyStimulus(0, 0, 0, 8'h00, 4'h4);
          applyStimulus(1, 0, 0, 8'h00, 4'hB);
        end
      end
    end
    checkOutput("t2_grants", grants, 4);
    checkOutput("t2_rsps", n_rsp, 4);
    wait_busy_low("t2_idle");

    // Three-byte burst on req1 with req_valid held: ss_b[1] low throughout, one NEXT cycle between bytes.
    $display("[TB] step 3: three-byte burst on req1");
    resp_lat = 2;
    expect_byte(1, 4'hB, 8'h11, 8'hE1, 1);
    expect_byte(1, 4'hB, 8'h22, 8'hE2, 1);
    expect_byte(1, 4'hB, 8'h33, 8'hE3, 1);
    applyStimulus(1, 1, 0, 8'h11, 4'hB);
    n_rsp      = 0;
    n_ready    = 0;
    prev_start = -1;
    cyc        = 0;
    for (int c = 0; c < 200 && n_rsp < 3; c++) begin
      tick();
      cyc++;
      if (bus.req_ready[1]) begin
        if (prev_start >= 0) checkOutput("t3_start_spacing", cyc - prev_start, resp_lat + 2);
        prev_start = cyc;
        n_ready++;
        if (n_ready == 1) applyStimulus(1, 1, 0, 8'h22, 4'hB);
        else if (n_ready == 2) applyStimulus(1, 1, 1, 8'h33, 4'hB);
        else applyStimulus(1, 0, 0, 8'h00, 4'hB);
      end
      if (bus.rsp_valid[1]) n_rsp++;
      if (n_rsp < 3) checkOutput("t3_ss_b_held", bus.ss_b, 2'b01);
    end
    checkOutput("t3_ready_pulses", n_ready, 3);
    checkOutput("t3_rsps", n_rsp, 3);
    wait_busy_low("t3_idle");

    // req0 stalls in NEXT for 50 cycles while req1 waits; cfg change and stray done are ignored.
    $display("[TB] step 4: stall in NEXT");
    expect_byte(0, 4'h4, 8'h70, 8'hF0, 1);
    expect_byte(0, 4'h4, 8'h77, 8'hF7, 1);
    expect_byte(1, 4'hB, 8'h88, 8'hF8, 1);
    applyStimulus(1, 1, 1, 8'h88, 4'hB);
    applyStimulus(0, 1, 0, 8'h70, 4'h4);
    wait_ready(0, "t4_first_ready");
    applyStimulus(0, 0, 0, 8'h00, 4'hF);
    for (int c = 0; c < 50; c++) begin
      tick();
      checkOutput("t4_ss_b_held", bus.ss_b, 2'b10);
      checkOutput("t4_no_ready", bus.req_ready, 2'b00);
      if (c == 20) begin
        rdata_manual = 8'hEE;
        done_manual  = 1'b1;
      end else begin
        done_manual  = 1'b0;
      end
    end
    applyStimulus(0, 1, 1, 8'h77, 4'hF);
    wait_ready(0, "t4_resume_ready");
    applyStimulus(0, 0, 0, 8'h00, 4'hF);
    high = 0;
    for (int c = 0; c < 100 && bus.ss_b != 2'b01; c++) begin
      tick();
      if (bus.ss_b == 2'b11) high++;
    end
    checkOutput("t4_req1_granted", bus.ss_b, 2'b01);
    checkOutput("t4_req1_after_gap", (high >= GAP_CYC), 1);
    wait_ready(1, "t4_req1_ready");
    applyStimulus(1, 0, 0, 8'h00, 4'hB);
    wait_busy_low("t4_idle");

    // Reset pulsed in WAIT: selects released at once, no response, later done ignored.
    $display("[TB] step 5: reset in WAIT");
    resp_en = 1'b0;
    expect_byte(0, 4'hF, 8'h99, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h99, 4'hF);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.xfer_start) begin
        found = 1;
        break;
      end
    end
    checkOutput("t5_start_seen", found, 1);
    applyStimulus(0, 0, 0, 8'h00, 4'hF);
    tick();
    checkOutput("t5_in_wait_ss_b", bus.ss_b, 2'b10);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_async_ss_b", bus.ss_b, 2'b11);
    checkOutput("t5_async_busy", bus.busy, 0);
    checkOutput("t5_async_ready", bus.req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rdata_manual = 8'h5E;
    done_manual  = 1'b1;
    tick();
    done_manual  = 1'b0;
    tick();
    tick();
    checkOutput("t5_idle_busy", bus.busy, 0);
    checkOutput("t5_idle_ss_b", bus.ss_b, 2'b11);
    checkOutput("t5_no_rsp", bus.rsp_valid, 0);
    resp_en = 1'b1;

`ifdef AVR_SPI_SCHED_TIMEOUT_EN
    // Watchdog: no done for req0, abort after TIMEOUT cycles in WAIT, then req1 served normally.
    $display("[TB] step 6: watchdog abort");
    resp_en = 1'b0;
    expect_byte(0, 4'hF, 8'hAB, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'hAB, 4'hF);
    wait_ready(0, "t6_start");
    applyStimulus(0, 0, 0, 8'h00, 4'hF);
    for (int k = 0; k < TIMEOUT; k++) begin
      tick();
      checkOutput("t6_err_not_yet", bus.timeout_err, 0);
    end
    tick();
    checkOutput("t6_timeout_err", bus.timeout_err, 1);
    checkOutput("t6_ss_b_released", bus.ss_b, 2'b11);
    checkOutput("t6_no_rsp", bus.rsp_valid, 0);
    resp_en  = 1'b1;
    resp_lat = 1;
    wait_busy_low("t6_gap_done");
    expect_byte(1, 4'hB, 8'h5A, 8'h33, 1);
    applyStimulus(1, 1, 1, 8'h5A, 4'hB);
    wait_ready(1, "t6_req1_ready");
    applyStimulus(1, 0, 0, 8'h00, 4'hB);
    wait_busy_low("t6_req1_idle");
    checkOutput("t6_err_sticky", bus.timeout_err, 1);
`else
    checkOutput("no_timeout_err", bus.timeout_err, 0);
`endif

    tick();
    tick();
    checkOutput("xfer_queue_drained", exp_xfer_q.size(), 0);
    checkOutput("rsp_queue_drained", exp_rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
